// File: rtl/bf_pdep_net.sv
// bf_pdep_net: bit-plane butterfly permutation engine with double-banked, per-group switch config.
// Optional BF_CFG_PARITY_EN stores an even-parity bit per config word and flags mismatches on lookup.
module bf_pdep_net #(
    parameter int DATA_WIDTH = 64,
    parameter int PLANES     = 8,
    parameter int NUM_GRP    = 4,
    parameter int CFG_DEPTH  = 4,
    parameter int ADDR_WIDTH = 2,
    parameter     PIPE_MASK  = 3'b101,
    localparam int STG = $clog2(DATA_WIDTH / PLANES),
    localparam int SW  = DATA_WIDTH / (2 * PLANES),
    localparam int GW  = NUM_GRP > 1 ? $clog2(NUM_GRP) : 1,
    localparam int KW  = STG > 1 ? $clog2(STG) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic [NUM_GRP*ADDR_WIDTH-1:0] s_addr,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    input  logic                          cfg_wr_en,
    input  logic [GW-1:0]                 cfg_grp,
    input  logic [ADDR_WIDTH-1:0]         cfg_entry,
    input  logic [KW-1:0]                 cfg_stage,
    input  logic [SW-1:0]                 cfg_data,
    input  logic                          cfg_inj_err,
    input  logic                          cfg_commit,
    input  logic                          err_clr,
    output logic                          err_addr,
    output logic                          err_par
);
    localparam int PPG = PLANES / NUM_GRP;
    localparam int CW  = STG * NUM_GRP * SW;

    function automatic logic [DATA_WIDTH-1:0] bf_stage(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [CW-1:0] c, input int k);
        logic [DATA_WIDTH-1:0] r;
        int b, lo, hi;
        r = d;
        b = STG - 1 - k;
        for (int p = 0; p < PLANES; p++)
            for (int j = 0; j < SW; j++) begin
                lo = ((j >> b) << (b + 1)) | (j & ((1 << b) - 1));
                hi = lo + (1 << b);
                if (c[(k * NUM_GRP + p / PPG) * SW + j]) begin
                    r[PLANES * lo + p] = d[PLANES * hi + p];
                    r[PLANES * hi + p] = d[PLANES * lo + p];
                end
            end
        return r;
    endfunction

    logic                  en, acc, wr_ok, bad_addr, bad_par;
    logic                  act_q, act_d, m_valid_q, err_addr_q, err_addr_d, err_par_q, err_par_d;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic [CW-1:0]         ctl_in;
    logic [SW-1:0]         ram_q [2][NUM_GRP][CFG_DEPTH][STG];
    logic [SW-1:0]         ram_d [2][NUM_GRP][CFG_DEPTH][STG];
    logic [DATA_WIDTH-1:0] dat [0:STG];
    logic                  vld [0:STG];
    logic [CW-1:0]         ctl [0:STG-1];

    assign en      = !m_valid_q || m_ready;
    assign s_ready = en;
    assign acc     = s_valid && en;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign err_addr = err_addr_q;
    assign wr_ok   = cfg_wr_en && int'(cfg_grp) < NUM_GRP && int'(cfg_entry) < CFG_DEPTH
                     && int'(cfg_stage) < STG;

    // Writes always target the bank that is shadow in this cycle, even when committing.
    always_comb begin
        ram_d = ram_q;
        if (wr_ok) ram_d[~act_q][cfg_grp][cfg_entry][cfg_stage] = cfg_data;
    end

`ifdef BF_CFG_PARITY_EN
    logic par_q [2][NUM_GRP][CFG_DEPTH][STG];
    logic par_d [2][NUM_GRP][CFG_DEPTH][STG];
    always_comb begin
        par_d = par_q;
        if (wr_ok) par_d[~act_q][cfg_grp][cfg_entry][cfg_stage] = ^cfg_data ^ cfg_inj_err;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int g = 0; g < NUM_GRP; g++)
                    for (int e = 0; e < CFG_DEPTH; e++)
                        for (int k = 0; k < STG; k++) par_q[b][g][e][k] <= 1'b0;
        end else par_q <= par_d;
`else
    logic unused_inj;
    assign unused_inj = cfg_inj_err;
`endif

    always_comb begin
        ctl_in   = '0;
        bad_addr = 1'b0;
        bad_par  = 1'b0;
        for (int g = 0; g < NUM_GRP; g++)
            if (int'(s_addr[g*ADDR_WIDTH +: ADDR_WIDTH]) < CFG_DEPTH) begin
                for (int k = 0; k < STG; k++) begin
                    ctl_in[(k*NUM_GRP + g)*SW +: SW] = ram_q[act_q][g][s_addr[g*ADDR_WIDTH +: ADDR_WIDTH]][k];
`ifdef BF_CFG_PARITY_EN
                    bad_par = bad_par | (^ram_q[act_q][g][s_addr[g*ADDR_WIDTH +: ADDR_WIDTH]][k]
                              ^ par_q[act_q][g][s_addr[g*ADDR_WIDTH +: ADDR_WIDTH]][k]);
`endif
                end
            end else bad_addr = 1'b1;
    end

    always_comb begin
        act_d      = act_q ^ cfg_commit;
        err_addr_d = (acc && bad_addr) || (err_addr_q && !err_clr);
        err_par_d  = (acc && bad_par) || (err_par_q && !err_clr);
    end

    assign dat[0] = s_data;
    assign vld[0] = acc;
    assign ctl[0] = ctl_in;

    for (genvar k = 0; k < STG; k++) begin : g_stg
        logic [DATA_WIDTH-1:0] perm_d;
        always_comb perm_d = bf_stage(dat[k], ctl[k], k);
        if (PIPE_MASK[k]) begin : g_reg
            logic [DATA_WIDTH-1:0] dat_q;
            logic                  vld_q;
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    dat_q <= '0;
                    vld_q <= 1'b0;
                end else if (en) begin
                    dat_q <= perm_d;
                    vld_q <= vld[k];
                end
            assign dat[k+1] = dat_q;
            assign vld[k+1] = vld_q;
            if (k < STG - 1) begin : g_ctl
                logic [CW-1:0] ctl_q;
                always_ff @(posedge clk or negedge rst_n)
                    if (!rst_n) ctl_q <= '0;
                    else if (en) ctl_q <= ctl[k];
                assign ctl[k+1] = ctl_q;
            end
        end else begin : g_thru
            assign dat[k+1] = perm_d;
            assign vld[k+1] = vld[k];
            if (k < STG - 1) begin : g_ctl
                assign ctl[k+1] = ctl[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            act_q      <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            err_addr_q <= 1'b0;
            err_par_q  <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int g = 0; g < NUM_GRP; g++)
                    for (int e = 0; e < CFG_DEPTH; e++)
                        for (int k = 0; k < STG; k++) ram_q[b][g][e][k] <= '0;
        end else begin
            act_q      <= act_d;
            err_addr_q <= err_addr_d;
            err_par_q  <= err_par_d;
            ram_q      <= ram_d;
            if (en) begin
                m_valid_q <= vld[STG];
                m_data_q  <= dat[STG];
            end
        end

`ifdef BF_CFG_PARITY_EN
    assign err_par = err_par_q;
`else
    logic unused_par;
    assign unused_par = err_par_q ^ err_par_d;
    assign err_par = 1'b0;
`endif
endmodule
